// File: rtl/regfile_writeback_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_writeback_ctrl_pkg
// Shared definitions for the register-file writeback controller:
//   - data / index widths and register count
//   - architectural register index names (S0..SP)
//   - stack-pointer index and its post-reset value
//   - controller FSM state encoding
//   - writeback requester identifiers used by the arbiter
// ----------------------------------------------------------------------------
package regfile_writeback_ctrl_pkg;

  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  // Architectural register names
  localparam logic [ADDR_W-1:0] S0 = 3'd0;
  localparam logic [ADDR_W-1:0] S1 = 3'd1;
  localparam logic [ADDR_W-1:0] S2 = 3'd2;
  localparam logic [ADDR_W-1:0] S3 = 3'd3;
  localparam logic [ADDR_W-1:0] T0 = 3'd4;
  localparam logic [ADDR_W-1:0] T1 = 3'd5;
  localparam logic [ADDR_W-1:0] RA = 3'd6;
  localparam logic [ADDR_W-1:0] SP = 3'd7;

  localparam logic [ADDR_W-1:0] SP_INDEX = SP;
  localparam logic [DATA_W-1:0] SP_INIT  = 10'h3FF;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_writeback_ctrl_arb.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter between the ALU and memory-load writebacks.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   enable               - arbitration allowed (controller in RUN)
//   req_alu, req_mem     - request lines (the requesters' valid signals)
//   accept               - a granted transfer actually happened this cycle
//   grant_alu, grant_mem - combinational one-hot (or zero) grant
// ----------------------------------------------------------------------------
module rr_arbiter2
  import regfile_writeback_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req_alu,
  input  logic req_mem,
  input  logic accept,
  output logic grant_alu,
  output logic grant_mem
);

  req_id_t last_grant;

  // Grant logic: a lone requester always wins; on a tie the requester that
  // did not win last time goes first. Nothing is granted while disabled.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (enable) begin
      if (req_alu && req_mem) begin
        if (last_grant == REQ_MEM) grant_alu = 1'b1;
        else                       grant_mem = 1'b1;
      end else begin
        grant_alu = req_alu;
        grant_mem = req_mem;
      end
    end
  end

  // Priority history: reset leaves MEM as the last winner so the ALU takes
  // the first tie; it only moves when a transfer is really accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_MEM;
    end else if (accept) begin
      last_grant <= grant_alu ? REQ_ALU : REQ_MEM;
    end
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_writeback_ctrl
// Owns the single write port of the 8 x 10-bit register file.
//   - After reset writes SP_INIT into the stack pointer, then enters RUN.
//   - Arbitrates ALU / load writebacks round-robin; accepted writes appear on
//     write_reg/write_data/reg_write_en one cycle later.
//   - Keeps a busy scoreboard of pending destinations for decode hazards.
// Ports:
//   clk, reset                         - clock, async active-high reset
//   alu_valid/alu_ready/alu_reg/alu_data - ALU writeback handshake
//   mem_valid/mem_ready/mem_reg/mem_data - load writeback handshake
//   issue_valid/issue_ready/issue_reg  - decode destination reservation
//   rs1/rs1_used/rs2/rs2_used          - decode source operands
//   stall                              - decode must hold its instruction
//   write_reg/write_data/reg_write_en  - register-file write port
//   busy                               - pending-write scoreboard
//   err_unexpected                     - sticky: commit to a non-busy reg
// ----------------------------------------------------------------------------
module regfile_writeback_ctrl
  import regfile_writeback_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_reg,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_reg,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic                rs1_used,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                rs2_used,
  output logic                stall,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data,
  output logic                reg_write_en,
  output logic [NUM_REGS-1:0] busy,
  output logic                err_unexpected
);

  wb_state_t           state_q, state_d;
  logic                run;
  logic                alu_accept, mem_accept;
  logic                init_write_q;
  logic                commit;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_d;

  assign run = (state_q == ST_RUN);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .enable    (run),
    .req_alu   (alu_valid),
    .req_mem   (mem_valid),
    .accept    (alu_accept | mem_accept),
    .grant_alu (alu_ready),
    .grant_mem (mem_ready)
  );

  assign alu_accept = alu_valid & alu_ready;
  assign mem_accept = mem_valid & mem_ready;

  // State register for the INIT -> RUN sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // INIT lasts exactly one clock (the SP write); RUN is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Registered write port. init_write_q marks the SP initialisation write so
  // the scoreboard and the error flag can ignore it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_en <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      init_write_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      reg_write_en <= 1'b1;
      write_reg    <= SP_INDEX;
      write_data   <= SP_INIT;
      init_write_q <= 1'b1;
    end else begin
      init_write_q <= 1'b0;
      if (alu_accept) begin
        reg_write_en <= 1'b1;
        write_reg    <= alu_reg;
        write_data   <= alu_data;
      end else if (mem_accept) begin
        reg_write_en <= 1'b1;
        write_reg    <= mem_reg;
        write_data   <= mem_data;
      end else begin
        reg_write_en <= 1'b0;
      end
    end
  end

  // Decode-side hazard view; sources are not bypassed, so a busy source
  // remains stalled through its own write cycle.
  assign issue_ready = run & ~busy[issue_reg];
  assign issue_fire  = issue_valid & issue_ready;
  assign stall       = ~run
                     | (rs1_used & busy[rs1])
                     | (rs2_used & busy[rs2])
                     | (issue_valid & ~issue_ready);

  assign commit = reg_write_en & ~init_write_q;

  // Next scoreboard: commits clear their destination, then a new issue sets
  // its destination, so a set on the same index wins over the clear.
  always_comb begin
    busy_d = busy;
    if (commit)     busy_d[write_reg] = 1'b0;
    if (issue_fire) busy_d[issue_reg] = 1'b1;
  end

  // Scoreboard and sticky error register; a commit to a register nobody
  // reserved is flagged but the write itself still goes through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy           <= '0;
      err_unexpected <= 1'b0;
    end else begin
      busy <= busy_d;
      if (commit && !busy[write_reg]) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_writeback_ctrl
// Self-checking bench for regfile_writeback_ctrl. Expected register-file
// writes are queued when a request is accepted and popped when the DUT
// drives reg_write_en. Inputs change on the falling edge; outputs are
// sampled at the falling edge or 1 time unit after an input change.
// ----------------------------------------------------------------------------
module tb_regfile_writeback_ctrl;
  import regfile_writeback_ctrl_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wb_t;

  logic                clk;
  logic                reset;
  logic                alu_valid, alu_ready;
  logic [ADDR_W-1:0]   alu_reg;
  logic [DATA_W-1:0]   alu_data;
  logic                mem_valid, mem_ready;
  logic [ADDR_W-1:0]   mem_reg;
  logic [DATA_W-1:0]   mem_data;
  logic                issue_valid, issue_ready;
  logic [ADDR_W-1:0]   issue_reg;
  logic [ADDR_W-1:0]   rs1, rs2;
  logic                rs1_used, rs2_used;
  logic                stall;
  logic [ADDR_W-1:0]   write_reg;
  logic [DATA_W-1:0]   write_data;
  logic                reg_write_en;
  logic [NUM_REGS-1:0] busy;
  logic                err_unexpected;

  int      checks = 0;
  int      errors = 0;
  wb_t     exp_q[$];
  req_id_t tb_last;

  regfile_writeback_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_reg        (alu_reg),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_reg        (mem_reg),
    .mem_data       (mem_data),
    .issue_valid    (issue_valid),
    .issue_reg      (issue_reg),
    .issue_ready    (issue_ready),
    .rs1            (rs1),
    .rs1_used       (rs1_used),
    .rs2            (rs2),
    .rs2_used       (rs2_used),
    .stall          (stall),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .reg_write_en   (reg_write_en),
    .busy           (busy),
    .err_unexpected (err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset behaviour, INIT gating and the SP initialisation write.
  task automatic test_reset();
    wb_t e;
    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    rs1_used = 1'b0; rs2_used = 1'b0;
    tick();
    tick();
    alu_valid = 1'b1; mem_valid = 1'b1; issue_valid = 1'b1; issue_reg = S0;
    #1;
    checks++;
    if ({reg_write_en, write_reg, write_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_port: got en=%b reg=%0d data=%h want 0/0/000", reg_write_en, write_reg, write_data);
    end
    checks++;
    if ({busy, err_unexpected} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_sb: got busy=%h err=%b want 00/0", busy, err_unexpected);
    end
    checks++;
    if ({alu_ready, mem_ready, issue_ready, stall} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_hs: got ar/mr/ir/st=%b want 0001", {alu_ready, mem_ready, issue_ready, stall});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({alu_ready, mem_ready, issue_ready, stall} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL init_hs: got ar/mr/ir/st=%b want 0001", {alu_ready, mem_ready, issue_ready, stall});
    end
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back('{r: SP_INDEX, d: SP_INIT});
    tb_last = REQ_MEM;
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL sp_init: expectation queue empty");
    end else begin
      e = exp_q.pop_front();
      if (reg_write_en !== 1'b1 || write_reg !== e.r || write_data !== e.d) begin
        errors++;
        $display("[TB] FAIL sp_init: got en=%b reg=%0d data=%h want 1/%0d/%h", reg_write_en, write_reg, write_data, e.r, e.d);
      end
    end
    tick();
    checks++;
    if ({reg_write_en, write_reg, busy, err_unexpected} !== {1'b0, SP_INDEX, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sp_after: got en=%b reg=%0d busy=%h err=%b want 0/7/00/0", reg_write_en, write_reg, busy, err_unexpected);
    end
  endtask

  // Both requesters valid every cycle: grants must alternate from ALU.
  task automatic test_round_robin();
    wb_t     e;
    req_id_t g;
    for (int i = 0; i < NUM_REGS; i++) begin
      issue_valid = 1'b1;
      issue_reg   = ADDR_W'(i);
      tick();
    end
    issue_valid = 1'b0;
    checks++;
    if (busy !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL rr_busy: got %h want ff", busy);
    end
    alu_valid = 1'b1; alu_reg = S1; alu_data = 10'h0A1;
    mem_valid = 1'b1; mem_reg = S2; mem_data = 10'h0B2;
    for (int beat = 0; beat < 6; beat++) begin
      #1;
      g = (tb_last == REQ_MEM) ? REQ_ALU : REQ_MEM;
      checks++;
      if ({alu_ready, mem_ready} !== ((g == REQ_ALU) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL rr_grant beat %0d: got ar/mr=%b want grant %s", beat, {alu_ready, mem_ready}, (g == REQ_ALU) ? "ALU" : "MEM");
      end
      if (g == REQ_ALU) exp_q.push_back('{r: alu_reg, d: alu_data});
      else              exp_q.push_back('{r: mem_reg, d: mem_data});
      tb_last = g;
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rr_write beat %0d: expectation queue empty", beat);
      end else begin
        e = exp_q.pop_front();
        if (reg_write_en !== 1'b1 || write_reg !== e.r || write_data !== e.d) begin
          errors++;
          $display("[TB] FAIL rr_write beat %0d: got en=%b reg=%0d data=%h want 1/%0d/%h", beat, reg_write_en, write_reg, write_data, e.r, e.d);
        end
      end
      if (g == REQ_ALU) alu_data = alu_data + 10'd1;
      else              mem_data = mem_data + 10'd1;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    checks++;
    if ({reg_write_en, err_unexpected} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rr_idle: got en=%b err=%b want 0/1", reg_write_en, err_unexpected);
    end
  endtask

  // Read-after-write: a busy source stalls through the write cycle.
  task automatic test_raw_hazard();
    wb_t e;
    issue_valid = 1'b1; issue_reg = T0;
    #1;
    checks++;
    if ({issue_ready, stall} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL raw_issue: got ir/st=%b want 10", {issue_ready, stall});
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy !== 8'h10) begin
      errors++;
      $display("[TB] FAIL raw_busy: got %h want 10", busy);
    end
    rs1 = T0; rs1_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL raw_stall: got %b want 1", stall);
    end
    alu_valid = 1'b1; alu_reg = T0; alu_data = 10'h155;
    #1;
    checks++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL raw_accept: got ar/mr=%b want 10", {alu_ready, mem_ready});
    end
    exp_q.push_back('{r: alu_reg, d: alu_data});
    tb_last = REQ_ALU;
    tick();
    alu_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL raw_write: expectation queue empty");
    end else begin
      e = exp_q.pop_front();
      if (reg_write_en !== 1'b1 || write_reg !== e.r || write_data !== e.d) begin
        errors++;
        $display("[TB] FAIL raw_write: got en=%b reg=%0d data=%h want 1/%0d/%h", reg_write_en, write_reg, write_data, e.r, e.d);
      end
    end
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL raw_stall_wcycle: got %b want 1", stall);
    end
    tick();
    checks++;
    if ({busy, stall, reg_write_en} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL raw_free: got busy=%h st=%b en=%b want 00/0/0", busy, stall, reg_write_en);
    end
    rs1_used = 1'b0;
  endtask

  // Write-after-write: issue to a busy destination waits for its commit.
  task automatic test_waw_issue();
    wb_t e;
    issue_valid = 1'b1; issue_reg = S3;
    tick();
    #1;
    checks++;
    if ({busy[S3], issue_ready, stall} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL waw_block: got busy3/ir/st=%b want 101", {busy[S3], issue_ready, stall});
    end
    alu_valid = 1'b1; alu_reg = S3; alu_data = 10'h2C3;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL waw_accept: got ar=%b want 1", alu_ready);
    end
    exp_q.push_back('{r: alu_reg, d: alu_data});
    tb_last = REQ_ALU;
    tick();
    alu_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL waw_write: expectation queue empty");
    end else begin
      e = exp_q.pop_front();
      if (reg_write_en !== 1'b1 || write_reg !== e.r || write_data !== e.d) begin
        errors++;
        $display("[TB] FAIL waw_write: got en=%b reg=%0d data=%h want 1/%0d/%h", reg_write_en, write_reg, write_data, e.r, e.d);
      end
    end
    #1;
    checks++;
    if ({issue_ready, stall} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL waw_wcycle: got ir/st=%b want 01", {issue_ready, stall});
    end
    tick();
    checks++;
    if ({busy[S3], issue_ready, stall} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL waw_release: got busy3/ir/st=%b want 010", {busy[S3], issue_ready, stall});
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if ({busy[S3], err_unexpected} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL waw_reissue: got busy3/err=%b want 10", {busy[S3], err_unexpected});
    end
  endtask

  // A load to a register that was never reserved raises the sticky flag.
  task automatic test_unexpected();
    wb_t e;
    mem_valid = 1'b1; mem_reg = T1; mem_data = 10'h0AA;
    #1;
    checks++;
    if ({alu_ready, mem_ready, busy[T1], err_unexpected} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL unexp_accept: got ar/mr/busy5/err=%b want 0100", {alu_ready, mem_ready, busy[T1], err_unexpected});
    end
    exp_q.push_back('{r: mem_reg, d: mem_data});
    tb_last = REQ_MEM;
    tick();
    mem_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexp_write: expectation queue empty");
    end else begin
      e = exp_q.pop_front();
      if (reg_write_en !== 1'b1 || write_reg !== e.r || write_data !== e.d) begin
        errors++;
        $display("[TB] FAIL unexp_write: got en=%b reg=%0d data=%h want 1/%0d/%h", reg_write_en, write_reg, write_data, e.r, e.d);
      end
    end
    tick();
    checks++;
    if (err_unexpected !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unexp_flag: got %b want 1", err_unexpected);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (err_unexpected !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unexp_sticky: got %b want 1", err_unexpected);
    end
  endtask

  // Reset arriving while a write sits on the port and a load is requesting.
  task automatic test_reset_mid();
    wb_t e;
    mem_valid = 1'b1; mem_reg = RA; mem_data = 10'h123;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_accept: got mr=%b want 1", mem_ready);
    end
    exp_q.push_back('{r: mem_reg, d: mem_data});
    tb_last = REQ_MEM;
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL mid_write: expectation queue empty");
    end else begin
      e = exp_q.pop_front();
      if (reg_write_en !== 1'b1 || write_reg !== e.r || write_data !== e.d) begin
        errors++;
        $display("[TB] FAIL mid_write: got en=%b reg=%0d data=%h want 1/%0d/%h", reg_write_en, write_reg, write_data, e.r, e.d);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({reg_write_en, write_reg, write_data, busy, err_unexpected} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_clear: got en=%b reg=%0d data=%h busy=%h err=%b want all 0", reg_write_en, write_reg, write_data, busy, err_unexpected);
    end
    checks++;
    if ({alu_ready, mem_ready, stall} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL mid_hs: got ar/mr/st=%b want 001", {alu_ready, mem_ready, stall});
    end
    tick();
    mem_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back('{r: SP_INDEX, d: SP_INIT});
    tb_last = REQ_MEM;
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL mid_sp: expectation queue empty");
    end else begin
      e = exp_q.pop_front();
      if (reg_write_en !== 1'b1 || write_reg !== e.r || write_data !== e.d) begin
        errors++;
        $display("[TB] FAIL mid_sp: got en=%b reg=%0d data=%h want 1/%0d/%h", reg_write_en, write_reg, write_data, e.r, e.d);
      end
    end
    tick();
    checks++;
    if ({reg_write_en, busy, err_unexpected} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL mid_after: got en=%b busy=%h err=%b want 0/00/0", reg_write_en, busy, err_unexpected);
    end
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    issue_valid = 1'b0; issue_reg = '0;
    rs1 = '0; rs1_used = 1'b0; rs2 = '0; rs2_used = 1'b0;
    tb_last = REQ_MEM;
    @(negedge clk);
    $display("[TB] reset and SP init");
    test_reset();
    $display("[TB] round-robin arbitration");
    test_round_robin();
    $display("[TB] reset again to clear sticky error");
    test_reset();
    $display("[TB] read-after-write hazard");
    test_raw_hazard();
    $display("[TB] write-after-write issue block");
    test_waw_issue();
    $display("[TB] unexpected commit");
    test_unexpected();
    $display("[TB] reset during traffic");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
Sequences the single write port of the 8 x 10-bit register file.
- Shares that port between the ALU writeback and memory-load writeback requesters using round-robin arbitration.
- Keeps a per-register busy scoreboard so decode can stall on read-after-write and write-after-write hazards.
- After reset, initialises the stack pointer before releasing the port to normal traffic.
- Sits between decode/execute/memory and the register file's write_reg/write_data/reg_write_en inputs.

Parameters:
DATA_W, 10, register data width
ADDR_W, 3, register index width
NUM_REGS, 8, number of architectural registers (2**ADDR_W)
SP_INDEX, 7, index of the stack-pointer register
SP_INIT, 10'h3FF, value written to SP after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_reg  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle
mem_reg  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
issue_valid  in  1  decode issues an instruction that will write issue_reg
issue_reg  in  ADDR_W  destination register of the issued instruction
issue_ready  out  1  issue accepted (destination not busy, controller in RUN)
rs1  in  ADDR_W  decode source register 1
rs1_used  in  1  rs1 is a true operand
rs2  in  ADDR_W  decode source register 2
rs2_used  in  1  rs2 is a true operand
stall  out  1  decode must hold the current instruction
write_reg  out  ADDR_W  register-file write address
write_data  out  DATA_W  register-file write data
reg_write_en  out  1  register-file write enable
busy  out  NUM_REGS  scoreboard, bit i = write to register i pending
err_unexpected  out  1  sticky: a writeback committed to a non-busy register

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high. It forces state=INIT, busy=0, err_unexpected=0, reg_write_en=0, write_reg=0, write_data=0, and last_grant=MEM, so the ALU wins the first tie.
- FSM:
  - INIT: alu_ready, mem_ready and issue_ready are 0. On the first rising edge with reset low, load reg_write_en=1, write_reg=SP_INDEX, write_data=SP_INIT, then go to RUN.
  - RUN: normal operation. The only way back to INIT is reset.
  - A reset in the middle of an operation discards any pending grant or output and reruns INIT.
- Arbitration (RUN only; combinational ready):
  - If only one requester is valid, it is granted.
  - If both are valid, grant the requester that is not last_grant.
  - At most one ready is high per cycle. ready never depends on ready.
  - A requester must hold valid, reg and data stable until accepted.
  - last_grant updates only on an accepted transfer.
- Writeback pipeline (registered, latency 1):
  - An accept in cycle N drives reg_write_en=1 with the latched reg/data in cycle N+1.
  - The register file captures at the end of cycle N+1.
  - With no accept, reg_write_en=0 in the next cycle and write_reg/write_data hold.
- Scoreboard:
  - Set: issue_valid & issue_ready sets busy[issue_reg] at the clock edge.
  - Clear: reg_write_en=1 clears busy[write_reg] at the clock edge of the write cycle.
  - Set and clear on the same index in the same cycle: set wins.
  - The SP initialisation write does not touch busy.
  - A commit to a register whose busy bit is 0 (SP init excluded) sets err_unexpected. The register write is still performed.
- Hazards (combinational):
  - issue_ready = RUN & ~busy[issue_reg].
  - stall = INIT | (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]) | (issue_valid & ~issue_ready).
  - No bypass: a source register stays stalled through the write cycle and is free in the cycle after.
- Width rules: indices are used unmodified (no wrap logic; all 8 are valid). Data passes through untouched.

Decomposition:
- Shared package:
  - Register index constants: S0=0, S1=1, S2=2, S3=3, T0=4, T1=5, RA=6, SP=7.
  - DATA_W/ADDR_W constants.
  - FSM state encoding: INIT, RUN.
  - Requester ID encoding: ALU=0, MEM=1.
- Sub-module rr_arbiter2: 2-way round-robin with last_grant register and accept input. All other logic stays in the top module.

Test Plan:
- Reset pulse then release → next cycle reg_write_en=1, write_reg=7, write_data=10'h3FF; the cycle after, reg_write_en=0; all ready=0 and stall=1 while in INIT.
- Issue with issue_reg=4 → busy=8'h10. Next cycle rs1=4, rs1_used=1 → stall=1. Then alu_valid, alu_reg=4, alu_data=10'h155 → alu_ready=1; the cycle after, reg_write_en=1, write_reg=4, write_data=10'h155. busy clears at that edge, and stall=0 on the following cycle.
- Both valid every cycle (alu_reg=1, mem_reg=2), all busy bits pre-set → grants alternate ALU, MEM, ALU, MEM starting with ALU. Each output write appears one cycle after its accept.
- busy[3]=1 and issue_valid, issue_reg=3 → issue_ready=0, stall=1. Once the write to reg 3 commits, issue_ready=1 on the following cycle.
- mem_valid with mem_reg=5 while busy[5]=0 → register still written; err_unexpected=1 and stays 1 until reset.
- Assert reset while mem_valid is high and a write is pending on the output → outputs clear immediately (async), busy=0, and the INIT SP write recurs after release.
